uart_rx_ctrl: RTL
=================

Name: uart_rx_ctrl

Overview:
Receive-side controller that sits between uart_rx and the system bus logic. It captures each completed frame from uart_rx into a FIFO, tagging each byte with its parity error status. It applies parity configuration only between frames, keeps saturating error and overflow statistics, and signals end-of-burst when the line stays idle. Downstream, bytes are presented on a first-word-fall-through valid/ready stream.

Parameters:
DATA_WIDTH, 8, byte width; must match uart_rx.
FIFO_DEPTH, 16, number of FIFO entries; power of 2, at least 2.
SAMPLING_RATE, 16, clk cycles per bit; must match uart_rx.
IDLE_BITS, 4, idle bit-periods after the last frame before idle_pulse fires.
CNT_WIDTH, 8, width of the statistics counters.

Ports:
clk  in  1  clock
rst  in  1  reset rst, synchronous, active-high; clock clk
cfg_parity_en  in  1  requested parity enable
drop_bad  in  1  1 = discard bytes that fail parity
clr_stats  in  1  synchronous clear of both counters
rx_data  in  DATA_WIDTH  uart_rx data
rx_valid  in  1  uart_rx parity-ok flag
rx_done  in  1  uart_rx frame-complete pulse, 1 cycle
rx_ready  in  1  uart_rx idle indicator
rx_parity  out  1  parity enable driven to uart_rx
m_data  out  DATA_WIDTH  head byte
m_err  out  1  parity error tag of the head byte
m_valid  out  1  FIFO non-empty
m_ready  in  1  consumer accept
fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH
parity_err_cnt  out  CNT_WIDTH  number of bytes that failed parity
overflow_cnt  out  CNT_WIDTH  number of bytes dropped because the FIFO was full
idle_pulse  out  1  one-cycle end-of-burst strobe

Behaviour:
- Reset values: rx_parity=0, m_valid=0, m_data=0, m_err=0, fifo_level=0, both counters=0, idle_pulse=0, idle FSM=DISARMED. Reset mid-frame discards all FIFO contents. Reset mid-count disarms the idle timer.
- Parity shadow:
  - rx_parity loads cfg_parity_en on any cycle with rx_ready=1. Otherwise it holds.
  - cfg_parity_en changes while rx_ready=0 therefore take effect only after the current frame ends.
- Capture:
  - Each rx_done cycle: err = !rx_valid.
  - If err=1: parity_err_cnt increments, whether or not the byte is stored.
  - If err=1 and drop_bad=1: the byte is discarded.
  - Otherwise the byte is pushed as {err, rx_data}.
- Full handling:
  - A push with the FIFO full and no pop in the same cycle drops the byte and increments overflow_cnt.
  - A push with the FIFO full and a pop in the same cycle is accepted; level stays at FIFO_DEPTH.
- Stream:
  - Pop occurs when m_valid && m_ready.
  - m_data and m_err always reflect the head entry, with no read latency.
  - A byte pushed in cycle N is visible on m_valid in cycle N+1.
  - Simultaneous push and pop on a non-empty FIFO leaves the level unchanged.
  - With the FIFO empty, a push and a pop cannot coincide, because m_valid=0.
- Pointers: wrap modulo FIFO_DEPTH. fifo_level = push count minus pop count.
- Counters:
  - Both saturate at 2^CNT_WIDTH-1.
  - clr_stats zeroes both counters and has priority over a coincident increment.
- Idle FSM:
  - DISARMED: any rx_done moves to ARMED and clears the timer.
  - ARMED:
    - If rx_ready=0, the timer clears.
    - Otherwise the timer increments.
    - When timer == IDLE_BITS*SAMPLING_RATE-1 with rx_ready=1, go to FIRE.
    - An rx_done while ARMED clears the timer.
  - FIRE: idle_pulse=1 for exactly one cycle, then DISARMED. An rx_done during FIRE arms again in the next state (goes to ARMED).
  - The timer width holds IDLE_BITS*SAMPLING_RATE.

Test Plan:
- Parity off, 3 frames (0xA5, 0x3C, 0xFF), m_ready=1 -> m_data streams A5, 3C, FF with m_err=0, each one cycle after its rx_done; parity_err_cnt=0.
- Parity on, drop_bad=0, rx_valid=0 on 0x55 -> entry 0x55 with m_err=1; parity_err_cnt=1. Repeat with drop_bad=1 -> nothing stored; parity_err_cnt=2.
- m_ready=0, 18 frames into a 16-deep FIFO -> fifo_level=16, overflow_cnt=2, first 16 bytes read back in order. Then push and pop in the same cycle while full -> level stays 16, overflow_cnt unchanged.
- Toggle cfg_parity_en while rx_ready=0 -> rx_parity unchanged until the first cycle with rx_ready=1.
- One frame, then the line stays idle -> idle_pulse high exactly 64 cycles after rx_ready returns (defaults 4*16), single cycle. A second frame before 64 cycles -> no pulse until 64 idle cycles after that frame.
- Force parity_err_cnt to 255, then another bad byte -> stays 255. clr_stats coincident with an increment -> 0. rst asserted with 5 bytes queued -> m_valid=0, fifo_level=0 next cycle.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: captures uart_rx frames into a parity-tagged FWFT FIFO with stats and idle detection
module uart_rx_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int SAMPLING_RATE = 16,
  parameter int IDLE_BITS     = 4,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_parity_en,
  input  logic                          drop_bad,
  input  logic                          clr_stats,
  input  logic [DATA_WIDTH-1:0]         rx_data,
  input  logic                          rx_valid,
  input  logic                          rx_done,
  input  logic                          rx_ready,
  output logic                          rx_parity,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          m_err,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_WIDTH-1:0]          parity_err_cnt,
  output logic [CNT_WIDTH-1:0]          overflow_cnt,
  output logic                          idle_pulse
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int LIM = IDLE_BITS * SAMPLING_RATE;
  localparam int TW  = $clog2(LIM + 1);
  typedef enum logic [1:0] {DISARMED, ARMED, FIRE} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [DATA_WIDTH:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH:0] head;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [CNT_WIDTH-1:0] perr_q, perr_d, ovf_q, ovf_d;
  logic parity_q, parity_d;
  logic err, push, full, pop, wr_en, ovf;
  // FIFO control, shadowed parity enable and saturating statistics
  always_comb begin
    err      = rx_done & ~rx_valid;
    push     = rx_done & ~(err & drop_bad);
    full     = level_q == LW'(FIFO_DEPTH);
    m_valid  = level_q != '0;
    pop      = m_valid & m_ready;
    wr_en    = push & (~full | pop);
    ovf      = push & full & ~pop;
    wptr_d   = wr_en ? wptr_q + 1'b1 : wptr_q;
    rptr_d   = pop ? rptr_q + 1'b1 : rptr_q;
    level_d  = level_q + LW'(wr_en) - LW'(pop);
    parity_d = rx_ready ? cfg_parity_en : parity_q;
    perr_d   = clr_stats ? '0 : (err && perr_q != '1) ? perr_q + 1'b1 : perr_q;
    ovf_d    = clr_stats ? '0 : (ovf && ovf_q != '1) ? ovf_q + 1'b1 : ovf_q;
    head     = mem_q[rptr_q];
    m_data   = m_valid ? head[DATA_WIDTH-1:0] : '0;
    m_err    = m_valid & head[DATA_WIDTH];
  end
  // Idle detector: arm on a frame, count continuous idle clocks, strobe once
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    idle_pulse = state_q == FIRE;
    if (state_q == DISARMED) begin
      state_d = rx_done ? ARMED : DISARMED;
      timer_d = '0;
    end else if (state_q == ARMED) begin
      if (rx_done || !rx_ready) timer_d = '0;
      else if (timer_q == TW'(LIM - 1)) state_d = FIRE;
      else timer_d = timer_q + 1'b1;
    end else begin
      state_d = rx_done ? ARMED : DISARMED;
      timer_d = '0;
    end
  end
  // State registers; storage array is left unreset since level gates its use
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DISARMED;
      timer_q  <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      perr_q   <= '0;
      ovf_q    <= '0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      perr_q   <= perr_d;
      ovf_q    <= ovf_d;
      parity_q <= parity_d;
    end
  end
  // FIFO storage write
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= {err, rx_data};
  end
  assign rx_parity      = parity_q;
  assign fifo_level     = level_q;
  assign parity_err_cnt = perr_q;
  assign overflow_cnt   = ovf_q;
endmodule
